// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and a multi-cycle
// shift-add multiplier; one operation in flight at a time.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [HALF-1:0]  a_r;
  logic [HALF-1:0]  b_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] out_r;
  logic             zero_r;
  logic             carry_r;
  logic             ovf_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             slt_s;
  logic [WIDTH-1:0] res_s;
  logic             cy_s;
  logic             ov_s;
  logic [WIDTH-1:0] pp_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             mul_last_s;
  logic             accept_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out       = out_r;
  assign zero      = zero_r;
  assign carry     = carry_r;
  assign ovf       = ovf_r;

  assign accept_s   = in_valid && (state_r == IDLE);
  assign sum_s      = {1'b0, A} + {1'b0, B};
  assign diff_s     = {1'b0, A} - {1'b0, B};
  assign slt_s      = ($signed(A) < $signed(B));
  assign mul_last_s = (cnt_r == CW'(HALF - 1));
  assign pp_s       = {{HALF{1'b0}}, a_r} << cnt_r;

  // Single-cycle result and flags for every op except MUL.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    cy_s  = 1'b0;
    ov_s  = 1'b0;
    case (op)
      OP_NOT: res_s = ~A;
      OP_OR:  res_s = A | B;
      OP_XOR: res_s = A ^ B;
      OP_AND: res_s = A & B;
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        cy_s  = sum_s[WIDTH];
        ov_s  = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s[WIDTH-1:0];
        cy_s  = diff_s[WIDTH];  // borrow out equals unsigned A < B
        ov_s  = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: res_s = {{(WIDTH-1){1'b0}}, slt_s};
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // Shift-add step: b_r is shifted right each cycle so bit 0 is the current multiplier bit.
  always_comb begin
    acc_next_s = acc_r;
    if (b_r[0]) begin
      acc_next_s = acc_r + pp_s;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = (op == OP_MUL) ? MUL_RUN : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      MUL_RUN: begin
        if (mul_last_s) begin
          state_s = DONE;
        end else begin
          state_s = MUL_RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, multiplier progress and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {HALF{1'b0}};
      b_r     <= {HALF{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      out_r   <= {WIDTH{1'b0}};
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r   <= A[HALF-1:0];
            b_r   <= B[HALF-1:0];
            acc_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            if (op != OP_MUL) begin
              out_r   <= res_s;
              zero_r  <= (res_s == {WIDTH{1'b0}});
              carry_r <= cy_s;
              ovf_r   <= ov_s;
            end
          end
        end
        MUL_RUN: begin
          acc_r <= acc_next_s;
          b_r   <= b_r >> 1;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (mul_last_s) begin
            out_r   <= acc_next_s;
            zero_r  <= (acc_next_s == {WIDTH{1'b0}});
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
          end
        end
        DONE: begin
          out_r <= out_r;
        end
        default: begin
          out_r <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq (WIDTH=8): a driver issues
// operations and queues expectations, a monitor checks every consumed result.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       zero;
  logic       carry;
  logic       ovf;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .carry(carry), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       zero;
    logic       carry;
    logic       ovf;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t scb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model straight from the op definitions, using integer arithmetic.
  function automatic exp_t model(input int a, input int b, input int o);
    exp_t e;
    int sa, sbv, r;
    sa = (a > 127) ? a - 256 : a;
    sbv = (b > 127) ? b - 256 : b;
    e.carry = 1'b0;
    e.ovf = 1'b0;
    case (o)
      0: r = 255 - a;
      1: r = a | b;
      2: r = a ^ b;
      3: r = a & b;
      4: r = (a % 16) * (b % 16);
      5: begin
        r = a + b;
        e.carry = (r > 255);
        e.ovf = ((sa + sbv) > 127) || ((sa + sbv) < -128);
        r = r % 256;
      end
      6: begin
        r = a - b;
        e.carry = (a < b);
        e.ovf = ((sa - sbv) > 127) || ((sa - sbv) < -128);
        r = (r + 256) % 256;
      end
      7: r = (sa < sbv) ? 1 : 0;
      default: r = 0;
    endcase
    e.out = r[7:0];
    e.zero = (r == 0);
    e.lat = (o == 4) ? 5 : 1;
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    int n = 0;
    exp_t e;
    @(negedge clk);
    A = a; B = b; op = o; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(int'(a), int'(b), int'(o));
    e.acc_cyc = cyc;
    scb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (scb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", scb.size(), 32'd0);
  endtask

  // Sink ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom);
      else out_ready = 1'b0;
    end
  end

  // Monitor: latency at first valid, full compare at each handshake.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev && scb.size() > 0)
          chk("latency", cyc - scb[0].acc_cyc, scb[0].lat);
        if (out_valid && out_ready) begin
          if (scb.size() == 0) begin
            chk("spurious_result", 32'd1, 32'd0);
          end else begin
            e = scb.pop_front();
            chk("out", out, e.out);
            chk("zero", zero, e.zero);
            chk("carry", carry, e.carry);
            chk("ovf", ovf, e.ovf);
          end
        end
        prev = out_valid;
      end
    end
  end

  initial begin
    exp_t h;
    int n;
    rst = 1'b1; in_valid = 1'b0; A = 8'h00; B = 8'h00; op = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", {out, zero, carry, ovf}, 11'h000);

    // Logic ops on F0/0F.
    for (int o = 0; o < 4; o++) issue(8'hF0, 8'h0F, 3'(o));
    wait_drain();

    // MUL with operands scrambled to zero while it runs.
    issue(8'hF5, 8'h0A, 3'b100);
    A = 8'h00; B = 8'h00;
    wait_drain();

    issue(8'h7F, 8'h01, 3'b101);
    issue(8'hFF, 8'h01, 3'b101);
    issue(8'h05, 8'h07, 3'b110);
    issue(8'h80, 8'h01, 3'b111);
    wait_drain();

    // Sink stall: result held, no acceptance, then release.
    rdy_mode = 2;
    issue(8'h12, 8'h34, 3'b101);
    h = model(32'h12, 32'h34, 5);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_out", out, h.out);
      in_valid = 1'($urandom); A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    chk("release_out_valid", out_valid, 1'b0);
    wait_drain();

    // Reset two cycles into a MUL aborts it.
    issue(8'h0F, 8'h0F, 3'b100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    scb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out", {out, zero, carry, ovf}, 11'h000);
    issue(8'h21, 8'h43, 3'b101);
    wait_drain();

    // Random traffic with a random sink.
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(8'($urandom), 8'($urandom), 3'($urandom));
    end
    rdy_mode = 0;
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
